// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter feeding one shared signed x unsigned multiplier.
// Two-stage pipeline: stage 1 registers the granted operands, stage 2
// registers the product. Results leave tagged with the requester index.
// Optional: define MUL_ARB_STALL_CNT_EN to add stall_clr / stall_cnt, a
// saturating count of cycles spent with out_valid && !out_ready.
module myproject_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 22,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DOUT_WIDTH-1:0]            out_dout,
  output logic [ID_WIDTH-1:0]              out_id,
`ifdef MUL_ARB_STALL_CNT_EN
  input  logic                             stall_clr,
  output logic [15:0]                      stall_cnt,
`endif
  output logic                             busy
);

  localparam int unsigned NR = NUM_REQ;
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  logic                         en;
  logic                         hs;
  logic                         found;
  logic [ID_WIDTH-1:0]          idx;
  logic [NUM_REQ-1:0]           grant;
  logic [ID_WIDTH-1:0]          gnt_id;
  logic [ID_WIDTH-1:0]          rr_ptr;

  logic                         s1_valid;
  logic signed [DIN0_WIDTH-1:0] s1_a;
  logic [DIN1_WIDTH-1:0]        s1_b;
  logic [ID_WIDTH-1:0]          s1_id;

  logic                         s2_valid;
  logic [DOUT_WIDTH-1:0]        s2_prod;
  logic [ID_WIDTH-1:0]          s2_id;

  logic signed [PW-1:0]         a_ext;
  logic signed [PW-1:0]         b_ext;
  logic signed [PW-1:0]         prod_full;
  logic [DOUT_WIDTH-1:0]        prod_out;

  // Whole pipeline advances unless the output beat is stuck downstream.
  always_comb en = !s2_valid || out_ready;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = ID_WIDTH'((32'(rr_ptr) + k) % NR);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = idx;
      end
    end
  end

  // Accept only when the pipeline can move and reset is released.
  always_comb begin
    req_ready = (en && ap_rst_n) ? grant : '0;
    hs        = |(req_valid & req_ready);
  end

  // Full-precision signed x zero-extended unsigned product.
  always_comb begin
    a_ext     = PW'(s1_a);
    b_ext     = PW'({1'b0, s1_b});
    prod_full = a_ext * b_ext;
  end

  generate
    if (DOUT_WIDTH >= PW) begin : g_ext
      // Sign-extend the product to the output width.
      always_comb prod_out = DOUT_WIDTH'(prod_full);
    end else begin : g_trunc
      // Keep the product LSBs when the output is narrower.
      always_comb prod_out = prod_full[DOUT_WIDTH-1:0];
    end
  endgenerate

  // Stage 1 and round-robin pointer: capture the granted operands.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (en) begin
      s1_valid <= hs;
      if (hs) begin
        rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        s1_a   <= req_din0[gnt_id*DIN0_WIDTH +: DIN0_WIDTH];
        s1_b   <= req_din1[gnt_id*DIN1_WIDTH +: DIN1_WIDTH];
        s1_id  <= gnt_id;
      end
    end
  end

  // Stage 2: register the product and its tag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_id    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_prod  <= prod_out;
      s2_id    <= s1_id;
    end
  end

  // Output channel and activity flag.
  always_comb begin
    out_valid = s2_valid;
    out_dout  = s2_prod;
    out_id    = s2_id;
    busy      = s1_valid || s2_valid;
  end

`ifdef MUL_ARB_STALL_CNT_EN
  // Saturating backpressure cycle counter; clear wins over increment.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (s2_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Directed bench for myproject_mul_share_arb with a scoreboard queue.
module tb_myproject_mul_share_arb;
  localparam int NR = 4;
  localparam int W0 = 14;
  localparam int W1 = 8;
  localparam int WO = 22;
  localparam int WI = 2;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic [NR-1:0]      req_valid = '0;
  logic [NR-1:0]      req_ready;
  logic [NR*W0-1:0]   req_din0 = '0;
  logic [NR*W1-1:0]   req_din1 = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [WO-1:0]      out_dout;
  logic [WI-1:0]      out_id;
  logic               busy;
`ifdef MUL_ARB_STALL_CNT_EN
  logic               stall_clr = 1'b0;
  logic [15:0]        stall_cnt;
`endif

  myproject_mul_share_arb #(
    .NUM_REQ(NR), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1),
    .DOUT_WIDTH(WO), .ID_WIDTH(WI)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dout(out_dout), .out_id(out_id),
`ifdef MUL_ARB_STALL_CNT_EN
    .stall_clr(stall_clr), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int            id;
    logic [WO-1:0] prod;
    int            step;
  } exp_t;

  exp_t          sb[$];
  int            gnt_log[$];
  int            npass = 0;
  int            ntot = 0;
  int            nfail = 0;
  int            step_no = 0;
  int            nbeat = 0;
  logic [WO-1:0] last_dout;
  bit            lat_chk = 1'b0;
  bit            pend[NR];
  bit            cont[NR];
  int            opa[NR];
  int            opb[NR];
  logic          or_drv = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WO-1:0] model(input int a, input int b);
    int p;
    p = a * b;
    return p[WO-1:0];
  endfunction

  task automatic new_op(input int i);
    opa[i] = int'($urandom_range(16383)) - 8192;
    opb[i] = int'($urandom_range(255));
  endtask

  function automatic bit any_pend();
    bit r;
    r = 1'b0;
    for (int i = 0; i < NR; i++) r |= pend[i];
    return r;
  endfunction

  // One clock: drive at negedge, observe settled handshakes and output beat.
  task automatic step();
    exp_t e;
    @(negedge ap_clk);
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pend[i];
      req_din0[i*W0 +: W0]   = opa[i][W0-1:0];
      req_din1[i*W1 +: W1]   = opb[i][W1-1:0];
    end
    out_ready = or_drv;
    #1;
    chk("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sb.push_back('{i, model(opa[i], opb[i]), step_no});
        gnt_log.push_back(i);
        if (cont[i]) new_op(i);
        else pend[i] = 1'b0;
      end
    end
    if (out_valid && out_ready) begin
      nbeat++;
      last_dout = out_dout;
      if (sb.size() == 0) begin
        chk("stray_beat", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("dout", 32'(out_dout), 32'(e.prod));
        chk("id", 32'(out_id), 32'(e.id));
        if (lat_chk) chk("latency", 32'(step_no - e.step), 32'd2);
      end
    end
    step_no++;
  endtask

  task automatic drain();
    or_drv = 1'b1;
    for (int i = 0; i < NR; i++) cont[i] = 1'b0;
    for (int n = 0; n < 40 && (sb.size() != 0 || any_pend()); n++) step();
    repeat (3) step();
    chk("drained", 32'(sb.size()), 32'd0);
    chk("pend_left", 32'(any_pend()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(out_dout), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    gnt_log.delete();
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      cont[i] = 1'b0;
    end
    req_valid = '0;
    or_drv    = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WO-1:0] hold_d;
    logic [WI-1:0] hold_i;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      cont[i] = 1'b0;
      opa[i]  = 0;
      opb[i]  = 0;
    end

    // Single request at the most negative operand extreme.
    do_reset();
    lat_chk = 1'b1;
    nbeat   = 0;
    pend[0] = 1'b1; opa[0] = -8192; opb[0] = 255;
    step();
    chk("single_gnt", 32'(gnt_log[0]), 32'd0);
    drain();
    chk("single_beats", 32'(nbeat), 32'd1);
    chk("single_dout", 32'(last_dout), 32'h202000);

    // Positive extreme plus a zero operand.
    pend[1] = 1'b1; opa[1] = 8191; opb[1] = 255;
    step();
    pend[2] = 1'b1; opa[2] = -1; opb[2] = 0;
    step();
    drain();

    // All requesters continuously valid: strict rotation, one result per cycle.
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      cont[i] = 1'b1;
      new_op(i);
    end
    repeat (8) step();
    chk("rot_count", 32'(gnt_log.size()), 32'd8);
    for (int n = 0; n < 8; n++) chk("rot_order", 32'(gnt_log[n]), 32'(n % NR));
    drain();

    // After serving req2, req3 must win over req1.
    do_reset();
    pend[2] = 1'b1; new_op(2);
    step();
    pend[1] = 1'b1; new_op(1);
    pend[3] = 1'b1; new_op(3);
    step();
    step();
    chk("prio_n", 32'(gnt_log.size()), 32'd3);
    chk("prio_0", 32'(gnt_log[0]), 32'd2);
    chk("prio_1", 32'(gnt_log[1]), 32'd3);
    chk("prio_2", 32'(gnt_log[2]), 32'd1);
    drain();

    // Backpressure for five cycles with both stages full.
    do_reset();
    lat_chk = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      cont[i] = 1'b1;
      new_op(i);
    end
    repeat (4) step();
    or_drv = 1'b0;
    step();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    hold_d = out_dout;
    hold_i = out_id;
    chk("bp_ready0", 32'(req_ready), 32'd0);
    repeat (4) begin
      step();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_dout_hold", 32'(out_dout), 32'(hold_d));
      chk("bp_id_hold", 32'(out_id), 32'(hold_i));
    end
    drain();

    // Asynchronous reset with both stages full, then restart from req0.
    do_reset();
    lat_chk = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      cont[i] = 1'b1;
      new_op(i);
    end
    repeat (4) step();
    @(posedge ap_clk);
    #2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    ap_rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    sb.delete();
    gnt_log.delete();
    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      cont[i] = 1'b0;
    end
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      new_op(i);
    end
    step();
    chk("post_rst_gnt", 32'(gnt_log[0]), 32'd0);
    drain();
    chk("post_rst_order", 32'(gnt_log.size()), 32'd4);

`ifdef MUL_ARB_STALL_CNT_EN
    // Stall counter: count, clear, saturate.
    do_reset();
    lat_chk = 1'b0;
    or_drv  = 1'b0;
    pend[0] = 1'b1; opa[0] = 100; opb[0] = 3;
    for (int n = 0; n < 10 && !out_valid; n++) step();
    chk("stall_wait", 32'(out_valid), 32'd1);
    chk("stall_start", 32'(stall_cnt), 32'd0);
    repeat (10) step();
    chk("stall_10", 32'(stall_cnt), 32'd10);
    stall_clr = 1'b1;
    step();
    chk("stall_clr", 32'(stall_cnt), 32'd0);
    stall_clr = 1'b0;
    repeat (70000) @(posedge ap_clk);
    #1;
    chk("stall_sat", 32'(stall_cnt), 32'd65535);
    drain();
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
